// File: rtl/opc2_boot_loader_if.sv
// Host byte stream plus CPU/RAM bus signals seen by the OPC-2 boot loader.
// master = host/CPU/RAM environment, slave = the loader.
interface opc2_boot_loader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rnw;
  logic              cpu_reset_b;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              err;

  modport master (
    output in_data, in_valid, cpu_address, cpu_wdata, cpu_rnw,
    input  in_ready, cpu_reset_b, mem_addr, mem_wdata, mem_we, busy, err
  );

  modport slave (
    input  in_data, in_valid, cpu_address, cpu_wdata, cpu_rnw,
    output in_ready, cpu_reset_b, mem_addr, mem_wdata, mem_we, busy, err
  );
endinterface

// File: rtl/opc2_boot_loader.sv
// OPC-2 boot loader: decodes framed host commands, writes RAM while the CPU
// is held in reset, and hands the RAM port back to the CPU on Go.
module opc2_boot_loader #(
  parameter int                ADDR_W   = 11,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] CMD_LOAD = 8'h4C,
  parameter logic [DATA_W-1:0] CMD_GO   = 8'h47,
  parameter logic [DATA_W-1:0] CMD_HALT = 8'h48
) (
  input logic               clk,
  input logic               reset_b,
  opc2_boot_loader_if.slave bus
);
  localparam int HI_W = ADDR_W - DATA_W;

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] load_addr, addr_nx;
  logic [ADDR_W-1:0] count, cnt_nx;
  logic              cpu_run, run_nx;
  logic              err_q, err_nx;
  logic [ADDR_W-1:0] ld_addr_q, la_nx;
  logic [DATA_W-1:0] ld_data_q, ld_nx;
  logic              ld_we_q, we_nx;
  logic              accept;

  assign accept = bus.in_valid & reset_b;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state     <= IDLE;
      load_addr <= '0;
      count     <= '0;
      cpu_run   <= 1'b0;
      err_q     <= 1'b0;
      ld_addr_q <= '0;
      ld_data_q <= '0;
      ld_we_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      load_addr <= addr_nx;
      count     <= cnt_nx;
      cpu_run   <= run_nx;
      err_q     <= err_nx;
      ld_addr_q <= la_nx;
      ld_data_q <= ld_nx;
      ld_we_q   <= we_nx;
    end
  end

  // Commands are only decoded in IDLE; inside a frame every byte is payload.
  always_comb begin
    state_nx = state;
    addr_nx  = load_addr;
    cnt_nx   = count;
    run_nx   = cpu_run;
    err_nx   = err_q;
    la_nx    = ld_addr_q;
    ld_nx    = ld_data_q;
    we_nx    = 1'b0;
    if (accept) begin
      unique case (state)
        IDLE: begin
          if (bus.in_data == CMD_LOAD) begin
            state_nx = ADDR_HI;
            run_nx   = 1'b0;
          end else if (bus.in_data == CMD_GO) begin
            run_nx = 1'b1;
            err_nx = 1'b0;
          end else if (bus.in_data == CMD_HALT) begin
            run_nx = 1'b0;
          end else begin
            err_nx = 1'b1;
          end
        end
        ADDR_HI: begin
          addr_nx  = {bus.in_data[HI_W-1:0], load_addr[DATA_W-1:0]};
          state_nx = ADDR_LO;
        end
        ADDR_LO: begin
          addr_nx  = {load_addr[ADDR_W-1:DATA_W], bus.in_data};
          state_nx = LEN_HI;
        end
        LEN_HI: begin
          cnt_nx   = {bus.in_data[HI_W-1:0], count[DATA_W-1:0]};
          state_nx = LEN_LO;
        end
        LEN_LO: begin
          cnt_nx   = {count[ADDR_W-1:DATA_W], bus.in_data};
          state_nx = DATA;
        end
        DATA: begin
          la_nx   = load_addr;
          ld_nx   = bus.in_data;
          we_nx   = 1'b1;
          addr_nx = load_addr + ADDR_W'(1);
          if (count == '0) state_nx = IDLE;
          else             cnt_nx   = count - ADDR_W'(1);
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign bus.in_ready    = reset_b;
  assign bus.cpu_reset_b = cpu_run;
  assign bus.busy        = (state != IDLE);
  assign bus.err         = err_q;

  // RAM port mux follows the CPU reset combinationally.
  assign bus.mem_addr  = cpu_run ? bus.cpu_address : ld_addr_q;
  assign bus.mem_wdata = cpu_run ? bus.cpu_wdata   : ld_data_q;
  assign bus.mem_we    = cpu_run ? ~bus.cpu_rnw    : ld_we_q;
endmodule

// File: doc/opc2_boot_loader.md
# opc2_boot_loader

Boot/load controller for the OPC-2 CPU's single 11-bit-address, 8-bit-data memory port. It sits between a host byte stream (UART or JTAG shim) and the system RAM. While the CPU is held in reset, the loader owns the RAM write port and fills memory from framed commands. On a Go command it hands the bus back to the CPU by releasing the CPU's reset. RAM read data goes straight from RAM to the CPU and does not pass through this block.

## Interface
Parameters:
- ADDR_W, 11, address width; matches the CPU address bus
- DATA_W, 8, data width
- CMD_LOAD, 8'h4C, load command byte ('L')
- CMD_GO, 8'h47, release-CPU command byte ('G')
- CMD_HALT, 8'h48, hold-CPU command byte ('H')

Ports:
- clk  in  1  single clock; all state on rising edge
- reset_b  in  1  asynchronous, active-low reset
- in_data  in  8  host byte
- in_valid  in  1  host byte valid
- in_ready  out  1  loader accepts byte; a byte transfers when in_valid & in_ready at a rising edge
- cpu_address  in  11  CPU address
- cpu_wdata  in  8  CPU write data (driven CPU data bus when cpu_rnw=0)
- cpu_rnw  in  1  CPU read-not-write
- cpu_reset_b  out  1  active-low reset to the CPU; 0 = halted, loader owns bus
- mem_addr  out  11  RAM address
- mem_wdata  out  8  RAM write data
- mem_we  out  1  RAM write enable, one cycle per byte
- busy  out  1  load frame in progress (state != IDLE)
- err  out  1  sticky: unknown command byte received

## Operation
- States: IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA.
- IDLE, on accepted byte:
  - CMD_LOAD → ADDR_HI; cpu_reset_b is cleared on the same edge.
  - CMD_GO → cpu_reset_b set to 1, err cleared; stay IDLE.
  - CMD_HALT → cpu_reset_b cleared to 0; stay IDLE.
  - Any other byte → err set to 1; stay IDLE.
- ADDR_HI: load_addr[10:8] <= in_data[2:0]; upper bits are ignored. → ADDR_LO.
- ADDR_LO: load_addr[7:0] <= in_data. → LEN_HI.
- LEN_HI: count[10:8] <= in_data[2:0]. → LEN_LO.
- LEN_LO: count[7:0] <= in_data. → DATA.
  - Count encodes length−1, so 0x000 = 1 byte and 0x7FF = 2048 bytes.
- DATA, each accepted byte:
  - Register a write of in_data to load_addr.
  - load_addr increments mod 2^11 (0x7FF wraps to 0x000).
  - If count==0 → IDLE, otherwise count decrements.
- Command bytes received inside a frame (header or DATA) are treated as plain data, never as commands.
- in_ready = reset_b; bytes are accepted every cycle with no backpressure.
- Bus mux:
  - cpu_reset_b=1: mem_addr=cpu_address, mem_wdata=cpu_wdata, mem_we=~cpu_rnw.
  - cpu_reset_b=0: mem_addr=ld_addr_q, mem_wdata=ld_data_q, mem_we=ld_we_q (registered loader write).
- The CPU is never released while busy:
  - CMD_GO is only decoded in IDLE.
  - A load started while the CPU runs halts it first.
- The CPU restarts from its own reset vector (0x100) on release. Frames normally target 0x100 upward; page zero is also loadable.

## Timing
- Reset values: state=IDLE, cpu_reset_b=0, mem_we=0, ld_we_q=0, ld_addr_q=0, ld_data_q=0, busy=0, err=0. in_ready=0 while reset_b=0.
- Loader write latency: a data byte accepted at edge N gives mem_we=1 with the matching addr/data during cycle N→N+1 only.
- Back-to-back bytes give back-to-back write cycles.
- cpu_reset_b changes on the edge that accepts the command byte (CMD_GO/CMD_HALT/CMD_LOAD). The bus mux follows it combinationally.
- Last data byte accepted at edge N: busy falls at N, and its write completes in cycle N+1. A CMD_GO accepted at N+1 releases the CPU at edge N+1, so the write has finished before the release.
- Async reset mid-frame: the frame is aborted, partial writes are kept in RAM, the CPU is held, and the next byte is decoded as a command.
- Minimum frame: 6 bytes, 6 cycles; RAM writes lag by 1 cycle.

## Test plan
- Reset release, no input → cpu_reset_b=0, mem_we=0, busy=0, err=0, in_ready=1.
- Stream 4C 01 00 00 02 AA BB CC, then 47 → mem_we pulses writing 0x100=AA, 0x101=BB, 0x102=CC on consecutive cycles; busy falls on the CC accept; cpu_reset_b=1 after the 47 edge; mem_addr then tracks cpu_address and mem_we tracks ~cpu_rnw.
- Wrap: 4C 07 FF 00 01 11 22 → writes 0x7FF=11, then 0x000=22.
- Command bytes as data: 4C 00 10 00 01 47 48 → 0x010=47, 0x011=48; cpu_reset_b stays 0 and err stays 0.
- Load while running: after 47, send 4C 00 20 00 00 5A → cpu_reset_b drops on the 4C edge and CPU writes are blocked; 0x020=5A is written. Then send 99 → err=1; then 47 → err=0 and cpu_reset_b=1.
- Assert reset_b mid-DATA → outputs return to reset values immediately. After release, 47 is accepted as CMD_GO.
